// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore-style control FSM for a multi-cycle MIPS datapath that shares a single
// memory port between instruction fetch and data access. Instructions are
// sequenced through FETCH, DECODE, execute, memory and write-back states. A
// mem_ready handshake lets the memory insert wait states.
//
// Most outputs are registered. They are computed from the next state, so they
// are valid for the whole cycle spent in that state. Only the strobes that
// must react to mem_ready or zero within the same cycle are combinational.
// Those are ir_write, mdr_write, the FETCH/BRANCH part of pc_write, and the
// MEM_WR part of instr_done. Each of them is gated by a registered state flag.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   opcode, func    IR[31:26] / IR[5:0], only looked at while in DECODE
//   zero            ALU zero flag, used in BRANCH
//   mem_ready       memory access completes this cycle
//   pc_write, iord, mem_read, mem_write, ir_write, mdr_write
//                   PC / memory / IR / MDR control
//   reg_dst, wb_sel, reg_write
//                   register-file write control
//   alu_src_a, alu_src_b, alu_operation
//                   ALU operand and operation select
//   pc_source       next-PC select
//   instr_done      one-cycle pulse in an instruction's last cycle
//   illegal         one-cycle pulse for an unknown opcode or func
// -----------------------------------------------------------------------------
module multicycle_controller #(
   parameter int MEM_HANDSHAKE = 1,
   parameter int ALUOP_W       = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic [5:0]         func,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               iord,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               mdr_write,
   output logic [1:0]         reg_dst,
   output logic [1:0]         wb_sel,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [ALUOP_W-1:0] alu_operation,
   output logic [1:0]         pc_source,
   output logic               instr_done,
   output logic               illegal
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR, S_MEM_RD,
      S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ILLEGAL
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b000);
   localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b001);
   localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b010);
   localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b110);
   localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b111);

   state_t               state_q, state_d;
   // Low from reset until the first clock after release. It holds the FSM and
   // all strobes idle during that cycle.
   logic                 active_q;

   // Instruction class captured in DECODE for the states that follow it.
   logic [ALUOP_W-1:0]   exec_op_q, exec_op_d;
   logic                 rd_sel_q, rd_sel_d;     // 1 = write rd, 0 = write rt
   logic                 is_lw_q, is_lw_d;
   logic                 is_bne_q, is_bne_d;

   // Combinational decode of the current IR fields.
   state_t               dec_state;
   logic [ALUOP_W-1:0]   dec_op;
   logic                 dec_rd, dec_lw, dec_bne;

   // Registered outputs and the state flags that qualify the Mealy strobes.
   logic                 pc_write_q, iord_q, mem_read_q, mem_write_q;
   logic [1:0]           reg_dst_q, wb_sel_q, alu_src_b_q, pc_source_q;
   logic                 reg_write_q, alu_src_a_q, done_q, illegal_q;
   logic [ALUOP_W-1:0]   alu_op_q;
   logic                 fetch_q, mem_rd_q, mem_wr_q, branch_q;

   logic                 ready;

   assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

   always_comb begin
      dec_state = S_ILLEGAL;
      dec_op    = ALU_ADD;
      dec_rd    = 1'b0;
      dec_lw    = 1'b0;
      dec_bne   = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            dec_rd    = 1'b1;
            dec_state = S_EXEC_R;
            case (func)
               FN_ADD:  dec_op = ALU_ADD;
               FN_SUB:  dec_op = ALU_SUB;
               FN_AND:  dec_op = ALU_AND;
               FN_OR:   dec_op = ALU_OR;
               FN_SLT:  dec_op = ALU_SLT;
               FN_JR:   dec_state = S_JR;
               default: dec_state = S_ILLEGAL;
            endcase
         end
         OP_LW: begin
            dec_state = S_MEM_ADDR;
            dec_lw    = 1'b1;
         end
         OP_SW:   dec_state = S_MEM_ADDR;
         OP_ADDI: begin
            dec_state = S_EXEC_I;
            dec_op    = ALU_ADD;
         end
         // andi uses the sign-extended immediate like every other I-type
         // because the datapath has no zero-extend path.
         OP_ANDI: begin
            dec_state = S_EXEC_I;
            dec_op    = ALU_AND;
         end
         OP_SLTI: begin
            dec_state = S_EXEC_I;
            dec_op    = ALU_SLT;
         end
         OP_BEQ:  dec_state = S_BRANCH;
         OP_BNE: begin
            dec_state = S_BRANCH;
            dec_bne   = 1'b1;
         end
         OP_J:    dec_state = S_JUMP;
         OP_JAL:  dec_state = S_JAL;
         default: dec_state = S_ILLEGAL;
      endcase
   end

   // While in DECODE the class comes straight from the IR. Elsewhere the
   // latched copy is used, so opcode/func may change after DECODE.
   always_comb begin
      exec_op_d = exec_op_q;
      rd_sel_d  = rd_sel_q;
      is_lw_d   = is_lw_q;
      is_bne_d  = is_bne_q;
      if (state_q == S_DECODE) begin
         exec_op_d = dec_op;
         rd_sel_d  = dec_rd;
         is_lw_d   = dec_lw;
         is_bne_d  = dec_bne;
      end
   end

   always_comb begin
      state_d = state_q;
      if (active_q) begin
         case (state_q)
            S_FETCH:    state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = dec_state;
            S_EXEC_R,
            S_EXEC_I:   state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = is_lw_q ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   state_d = ready ? S_FETCH : S_MEM_WR;
            default:    state_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FETCH;
         active_q    <= 1'b0;
         exec_op_q   <= '0;
         rd_sel_q    <= 1'b0;
         is_lw_q     <= 1'b0;
         is_bne_q    <= 1'b0;
         pc_write_q  <= 1'b0;
         iord_q      <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         reg_dst_q   <= 2'b00;
         wb_sel_q    <= 2'b00;
         reg_write_q <= 1'b0;
         alu_src_a_q <= 1'b0;
         alu_src_b_q <= 2'b00;
         alu_op_q    <= '0;
         pc_source_q <= 2'b00;
         done_q      <= 1'b0;
         illegal_q   <= 1'b0;
         fetch_q     <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         branch_q    <= 1'b0;
      end else begin
         active_q    <= 1'b1;
         state_q     <= state_d;
         exec_op_q   <= exec_op_d;
         rd_sel_q    <= rd_sel_d;
         is_lw_q     <= is_lw_d;
         is_bne_q    <= is_bne_d;

         pc_write_q  <= 1'b0;
         iord_q      <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         reg_dst_q   <= 2'b00;
         wb_sel_q    <= 2'b00;
         reg_write_q <= 1'b0;
         alu_src_a_q <= 1'b0;
         alu_src_b_q <= 2'b00;
         alu_op_q    <= ALU_AND;
         pc_source_q <= 2'b00;
         done_q      <= 1'b0;
         illegal_q   <= 1'b0;
         fetch_q     <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         branch_q    <= 1'b0;

         case (state_d)
            S_FETCH: begin
               fetch_q     <= 1'b1;
               mem_read_q  <= 1'b1;
               alu_src_b_q <= 2'b01;
               alu_op_q    <= ALU_ADD;
            end
            S_DECODE: begin
               alu_src_b_q <= 2'b11;
               alu_op_q    <= ALU_ADD;
            end
            S_EXEC_R: begin
               alu_src_a_q <= 1'b1;
               alu_op_q    <= exec_op_d;
            end
            S_EXEC_I: begin
               alu_src_a_q <= 1'b1;
               alu_src_b_q <= 2'b10;
               alu_op_q    <= exec_op_d;
            end
            S_WB_ALU: begin
               reg_write_q <= 1'b1;
               reg_dst_q   <= rd_sel_d ? 2'b01 : 2'b00;
               done_q      <= 1'b1;
            end
            S_MEM_ADDR: begin
               alu_src_a_q <= 1'b1;
               alu_src_b_q <= 2'b10;
               alu_op_q    <= ALU_ADD;
            end
            S_MEM_RD: begin
               mem_rd_q    <= 1'b1;
               mem_read_q  <= 1'b1;
               iord_q      <= 1'b1;
            end
            S_WB_MEM: begin
               reg_write_q <= 1'b1;
               wb_sel_q    <= 2'b01;
               done_q      <= 1'b1;
            end
            S_MEM_WR: begin
               mem_wr_q    <= 1'b1;
               mem_write_q <= 1'b1;
               iord_q      <= 1'b1;
            end
            S_BRANCH: begin
               branch_q    <= 1'b1;
               alu_src_a_q <= 1'b1;
               alu_op_q    <= ALU_SUB;
               pc_source_q <= 2'b01;
               done_q      <= 1'b1;
            end
            S_JUMP: begin
               pc_write_q  <= 1'b1;
               pc_source_q <= 2'b10;
               done_q      <= 1'b1;
            end
            // PC already holds PC+4 from FETCH, which is the return address.
            S_JAL: begin
               pc_write_q  <= 1'b1;
               pc_source_q <= 2'b10;
               reg_write_q <= 1'b1;
               reg_dst_q   <= 2'b10;
               wb_sel_q    <= 2'b10;
               done_q      <= 1'b1;
            end
            S_JR: begin
               pc_write_q  <= 1'b1;
               pc_source_q <= 2'b11;
               done_q      <= 1'b1;
            end
            S_ILLEGAL: begin
               illegal_q   <= 1'b1;
               done_q      <= 1'b1;
            end
            default: begin
               done_q      <= 1'b0;
            end
         endcase
      end
   end

   assign pc_write      = pc_write_q | (fetch_q & ready) | (branch_q & (zero ^ is_bne_q));
   assign ir_write      = fetch_q & ready;
   assign mdr_write     = mem_rd_q & ready;
   assign instr_done    = done_q | (mem_wr_q & ready);
   assign iord          = iord_q;
   assign mem_read      = mem_read_q;
   assign mem_write     = mem_write_q;
   assign reg_dst       = reg_dst_q;
   assign wb_sel        = wb_sel_q;
   assign reg_write     = reg_write_q;
   assign alu_src_a     = alu_src_a_q;
   assign alu_src_b     = alu_src_b_q;
   assign alu_operation = alu_op_q;
   assign pc_source     = pc_source_q;
   assign illegal       = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Each scenario queues one stimulus word and one expected output vector per
// clock cycle. The task then replays the queue. It drives each cycle after
// the rising edge and compares all outputs at the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

   typedef enum int {
      T_RST, T_F, T_D, T_EXR, T_EXI, T_WBA, T_MA, T_MRD, T_WBM, T_MWR,
      T_BR, T_J, T_JAL, T_JR, T_ILL
   } tst_e;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] func = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       pc_write, iord, mem_read, mem_write, ir_write, mdr_write;
   logic [1:0] reg_dst, wb_sel, alu_src_b, pc_source;
   logic       reg_write, alu_src_a, instr_done, illegal;
   logic [2:0] alu_operation;

   int checks = 0;
   int errors = 0;

   logic [13:0] stim_q[$];   // {mem_ready, zero, opcode, func}
   logic [20:0] exp_q[$];
   logic [5:0]  cur_op, cur_fn;
   logic        cur_zr;

   wire [20:0] out_vec = {pc_write, iord, mem_read, mem_write, ir_write, mdr_write,
                          reg_dst, wb_sel, reg_write, alu_src_a, alu_src_b,
                          alu_operation, pc_source, instr_done, illegal};

   multicycle_controller #(.MEM_HANDSHAKE(1), .ALUOP_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .mdr_write(mdr_write),
      .reg_dst(reg_dst), .wb_sel(wb_sel), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_operation(alu_operation),
      .pc_source(pc_source), .instr_done(instr_done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Expected outputs for one cycle in a given state, taken from the state
   // table. For exec states x is the ALU op, for WB_ALU x is reg_dst, and
   // for BRANCH x[0] is the expected pc_write.
   function automatic logic [20:0] model(tst_e st, logic rdy, logic [2:0] x);
      logic pcw, io, mr, mw, irw, mdrw, rw, sa, done, ill;
      logic [1:0] rd, wb, sb, pcs;
      logic [2:0] aop;
      pcw = 0; io = 0; mr = 0; mw = 0; irw = 0; mdrw = 0; rw = 0; sa = 0;
      done = 0; ill = 0; rd = 0; wb = 0; sb = 0; pcs = 0; aop = 0;
      case (st)
         T_F:   begin mr = 1; sb = 2'b01; aop = 3'b010; pcw = rdy; irw = rdy; end
         T_D:   begin sb = 2'b11; aop = 3'b010; end
         T_EXR: begin sa = 1; aop = x; end
         T_EXI: begin sa = 1; sb = 2'b10; aop = x; end
         T_WBA: begin rw = 1; rd = x[1:0]; done = 1; end
         T_MA:  begin sa = 1; sb = 2'b10; aop = 3'b010; end
         T_MRD: begin mr = 1; io = 1; mdrw = rdy; end
         T_WBM: begin rw = 1; wb = 2'b01; done = 1; end
         T_MWR: begin mw = 1; io = 1; done = rdy; end
         T_BR:  begin sa = 1; aop = 3'b110; pcs = 2'b01; pcw = x[0]; done = 1; end
         T_J:   begin pcw = 1; pcs = 2'b10; done = 1; end
         T_JAL: begin pcw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; wb = 2'b10; done = 1; end
         T_JR:  begin pcw = 1; pcs = 2'b11; done = 1; end
         T_ILL: begin ill = 1; done = 1; end
         default: begin ill = 0; end
      endcase
      return {pcw, io, mr, mw, irw, mdrw, rd, wb, rw, sa, sb, aop, pcs, done, ill};
   endfunction

   task automatic push(tst_e st, logic rdy, logic [2:0] x);
      stim_q.push_back({rdy, cur_zr, cur_op, cur_fn});
      exp_q.push_back(model(st, rdy, x));
   endtask

   task automatic drive(logic [13:0] s);
      {mem_ready, zero, opcode, func} = s;
   endtask

   task automatic test_reset;
      logic [20:0] want;
      rst_n = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      want = model(T_RST, 1'b1, 3'd0);
      checks++;
      if (out_vec !== want) begin
         errors++; $display("FAIL reset_outputs got=%h want=%h", out_vec, want);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      // First instruction after release: j, which starts in FETCH.
      cur_op = 6'b000010; cur_fn = 6'd0; cur_zr = 1'b0;
      push(T_F, 1, 0); push(T_D, 1, 0); push(T_J, 1, 0);
      for (int n = 0; exp_q.size() != 0; n++) begin
         drive(stim_q.pop_front());
         @(negedge clk);
         want = exp_q.pop_front(); checks++;
         if (out_vec !== want) begin
            errors++; $display("FAIL reset_first_fetch cyc%0d got=%h want=%h", n, out_vec, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_add;
      logic [20:0] want;
      cur_op = 6'b000000; cur_fn = 6'b100000; cur_zr = 1'b0;
      push(T_F, 1, 0); push(T_D, 1, 0); push(T_EXR, 1, 3'b010); push(T_WBA, 1, 3'b001);
      for (int n = 0; exp_q.size() != 0; n++) begin
         drive(stim_q.pop_front());
         @(negedge clk);
         want = exp_q.pop_front(); checks++;
         if (out_vec !== want) begin
            errors++; $display("FAIL add cyc%0d got=%h want=%h", n, out_vec, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_lw_wait;
      logic [20:0] want;
      cur_op = 6'b100011; cur_fn = 6'b010101; cur_zr = 1'b0;
      push(T_F, 0, 0); push(T_F, 0, 0); push(T_F, 1, 0); push(T_D, 1, 0);
      push(T_MA, 1, 0);
      push(T_MRD, 0, 0); push(T_MRD, 0, 0); push(T_MRD, 0, 0); push(T_MRD, 1, 0);
      push(T_WBM, 1, 0);
      for (int n = 0; exp_q.size() != 0; n++) begin
         drive(stim_q.pop_front());
         @(negedge clk);
         want = exp_q.pop_front(); checks++;
         if (out_vec !== want) begin
            errors++; $display("FAIL lw_wait cyc%0d got=%h want=%h", n, out_vec, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch;
      logic [20:0] want;
      // {beq,z=1 -> taken}, {bne,z=1 -> not}, {beq,z=0 -> not}, {bne,z=0 -> taken}
      for (int b = 0; b < 4; b++) begin
         cur_op = b[0] ? 6'b000101 : 6'b000100;
         cur_zr = (b < 2);
         cur_fn = 6'd0;
         push(T_F, 1, 0); push(T_D, 1, 0);
         push(T_BR, 1, {2'b00, cur_zr ^ b[0]});
      end
      for (int n = 0; exp_q.size() != 0; n++) begin
         drive(stim_q.pop_front());
         @(negedge clk);
         want = exp_q.pop_front(); checks++;
         if (out_vec !== want) begin
            errors++; $display("FAIL branch cyc%0d got=%h want=%h", n, out_vec, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_jal_jr;
      logic [20:0] want;
      cur_op = 6'b000011; cur_fn = 6'd0; cur_zr = 1'b0;
      push(T_F, 1, 0); push(T_D, 1, 0); push(T_JAL, 1, 0);
      cur_op = 6'b000000; cur_fn = 6'b001000;
      push(T_F, 1, 0); push(T_D, 1, 0); push(T_JR, 1, 0);
      for (int n = 0; exp_q.size() != 0; n++) begin
         drive(stim_q.pop_front());
         @(negedge clk);
         want = exp_q.pop_front(); checks++;
         if (out_vec !== want) begin
            errors++; $display("FAIL jal_jr cyc%0d got=%h want=%h", n, out_vec, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal;
      logic [20:0] want;
      cur_op = 6'b111111; cur_fn = 6'd0; cur_zr = 1'b0;
      push(T_F, 1, 0); push(T_D, 1, 0); push(T_ILL, 1, 0);
      cur_op = 6'b000000; cur_fn = 6'b000111;
      push(T_F, 1, 0); push(T_D, 1, 0); push(T_ILL, 1, 0);
      for (int n = 0; exp_q.size() != 0; n++) begin
         drive(stim_q.pop_front());
         @(negedge clk);
         want = exp_q.pop_front(); checks++;
         if (out_vec !== want) begin
            errors++; $display("FAIL illegal cyc%0d got=%h want=%h", n, out_vec, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back;
      logic [20:0] want;
      logic [2:0]  aop;
      logic        is_r;
      cur_zr = 1'b0;
      for (int i = 0; i < 7; i++) begin
         case (i)
            0: begin cur_op = 6'b000000; cur_fn = 6'b100010; aop = 3'b110; is_r = 1; end
            1: begin cur_op = 6'b000000; cur_fn = 6'b100100; aop = 3'b000; is_r = 1; end
            2: begin cur_op = 6'b000000; cur_fn = 6'b100101; aop = 3'b001; is_r = 1; end
            3: begin cur_op = 6'b000000; cur_fn = 6'b101010; aop = 3'b111; is_r = 1; end
            4: begin cur_op = 6'b001000; cur_fn = 6'b100010; aop = 3'b010; is_r = 0; end
            5: begin cur_op = 6'b001100; cur_fn = 6'b000000; aop = 3'b000; is_r = 0; end
            default: begin cur_op = 6'b001010; cur_fn = 6'b000000; aop = 3'b111; is_r = 0; end
         endcase
         push(T_F, 1, 0); push(T_D, 1, 0);
         push(is_r ? T_EXR : T_EXI, 1, aop);
         push(T_WBA, 1, is_r ? 3'b001 : 3'b000);
      end
      // sw with one wait state on the write.
      cur_op = 6'b101011; cur_fn = 6'd0;
      push(T_F, 1, 0); push(T_D, 1, 0); push(T_MA, 1, 0);
      push(T_MWR, 0, 0); push(T_MWR, 1, 0);
      for (int n = 0; exp_q.size() != 0; n++) begin
         drive(stim_q.pop_front());
         // Scramble IR fields after DECODE to show the latched class is used.
         if (n % 4 >= 2 && n < 28) begin opcode = 6'b111111; func = 6'b111111; end
         @(negedge clk);
         want = exp_q.pop_front(); checks++;
         if (out_vec !== want) begin
            errors++; $display("FAIL back_to_back cyc%0d got=%h want=%h", n, out_vec, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_memwr;
      logic [20:0] want;
      cur_op = 6'b101011; cur_fn = 6'd0; cur_zr = 1'b0;
      push(T_F, 1, 0); push(T_D, 1, 0); push(T_MA, 1, 0); push(T_MWR, 0, 0);
      for (int n = 0; exp_q.size() != 0; n++) begin
         drive(stim_q.pop_front());
         @(negedge clk);
         want = exp_q.pop_front(); checks++;
         if (out_vec !== want) begin
            errors++; $display("FAIL reset_memwr cyc%0d got=%h want=%h", n, out_vec, want);
         end
         @(posedge clk); #1;
      end
      // Still waiting in MEM_WR; reset now, between clock edges.
      checks++;
      if (mem_write !== 1'b1) begin
         errors++; $display("FAIL memwr_hold got=%b want=1", mem_write);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (out_vec !== 21'd0) begin
         errors++; $display("FAIL memwr_async_reset got=%h want=%h", out_vec, 21'd0);
      end
      mem_ready = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      cur_op = 6'b000010; cur_fn = 6'd0;
      push(T_F, 1, 0); push(T_D, 1, 0); push(T_J, 1, 0);
      for (int n = 0; exp_q.size() != 0; n++) begin
         drive(stim_q.pop_front());
         @(negedge clk);
         want = exp_q.pop_front(); checks++;
         if (out_vec !== want) begin
            errors++; $display("FAIL restart cyc%0d got=%h want=%h", n, out_vec, want);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset;
      test_add;
      test_lw_wait;
      test_branch;
      test_jal_jr;
      test_illegal;
      test_back_to_back;
      test_reset_memwr;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle MIPS control unit: a Moore-style FSM that sequences fetch, decode, execute, memory and write-back across several clock cycles.
- Shares one memory port for instructions and data. Supports a ready handshake so memory wait states can be inserted.
- Drives the multi-cycle datapath muxes, register enables and ALU operation.
- Decodes the existing ISA (R-type add/sub/and/or/slt, jr, lw, sw, beq, bne, j, jal, addi, andi) plus slti, and flags illegal opcodes.

Parameters:
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
- ALUOP_W, 3, width of alu_operation.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  IR[31:26], valid from the DECODE state onward.
- func  input  6  IR[5:0].
- zero  input  1  ALU zero flag, combinational in the BRANCH state.
- mem_ready  input  1  memory access complete this cycle.
- pc_write  output  1  PC register enable.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  IR enable.
- mdr_write  output  1  MDR enable.
- reg_dst  output  2  write register select: 00 = rt, 01 = rd, 10 = r31.
- wb_sel  output  2  write-back data select: 00 = ALUOut, 01 = MDR, 10 = PC.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = reg A.
- alu_src_b  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- alu_operation  output  ALUOP_W  ALU operation: 000 = AND, 001 = OR, 010 = ADD, 110 = SUB, 111 = SLT.
- pc_source  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = reg A.
- instr_done  output  1  one-cycle pulse in an instruction's last cycle.
- illegal  output  1  one-cycle pulse when an unknown opcode or func is decoded.

Behaviour:
- Reset
  - rst_n low: state = FETCH immediately (asynchronous) and all outputs are forced to 0.
  - Outputs are decoded from state after rst_n rises. FETCH is entered with its strobes asserted in the first clock after release.
- Outputs not listed for a state are 0.
- FETCH
  - Asserts mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_operation=ADD, pc_source=00.
  - ir_write and pc_write are asserted only when mem_ready=1 (always asserted if MEM_HANDSHAKE=0).
  - Stays in FETCH while mem_ready=0; advances to DECODE when mem_ready=1.
- DECODE
  - Computes the branch target: alu_src_a=0, alu_src_b=11, ADD.
  - Dispatches on opcode/func:
    - R-type (not jr) -> EXEC_R
    - jr -> JR
    - lw, sw -> MEM_ADDR
    - addi, andi, slti -> EXEC_I
    - beq, bne -> BRANCH
    - j -> JUMP
    - jal -> JAL
    - anything else, including an unknown R-type func -> ILLEGAL.
- EXEC_R: alu_src_a=1, alu_src_b=00.
  - ALU op by func: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - Next state WB_ALU with reg_dst=01.
- EXEC_I: alu_src_a=1, alu_src_b=10.
  - ALU op: addi ADD, andi AND (sign-extended imm, matching the datapath), slti SLT.
  - Next state WB_ALU with reg_dst=00.
- WB_ALU: reg_write=1, wb_sel=00, reg_dst held from the execute class; instr_done=1; next state FETCH.
  - The reg_dst class is stored in a 1-bit register captured in DECODE.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD; next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD
  - Asserts mem_read=1, iord=1; mdr_write is asserted when mem_ready=1.
  - Waits for mem_ready, then goes to WB_MEM.
- WB_MEM: reg_write=1, reg_dst=00, wb_sel=01; instr_done=1; next state FETCH.
- MEM_WR
  - Asserts mem_write=1, iord=1 for every cycle until mem_ready=1.
  - instr_done=1 in the cycle mem_ready=1; then FETCH.
- BRANCH
  - alu_src_a=1, alu_src_b=00, SUB, pc_source=01.
  - pc_write = zero for beq, ~zero for bne (Mealy on zero).
  - instr_done=1; next state FETCH.
- JUMP: pc_write=1, pc_source=10; instr_done=1; next state FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, wb_sel=10; instr_done=1; next state FETCH.
  - The PC is already PC+4 at this point, so r31 receives the return address.
- JR: pc_write=1, pc_source=11; instr_done=1; next state FETCH.
- ILLEGAL: illegal=1, instr_done=1, no write strobes; next state FETCH. The PC has already advanced by 4, so the instruction is skipped.
- Latency with zero wait states:
  - R-type, I-type ALU, sw: 4 cycles.
  - lw: 5 cycles.
  - beq, bne, j, jal, jr, illegal: 3 cycles.
  - Each mem_ready=0 cycle adds one cycle.
- Opcode/func are sampled combinationally in DECODE only; later states use the latched class.
- Reset asserted mid-instruction aborts the instruction at once: pending writes are dropped and no strobes remain asserted.

Test Plan:
- Reset: hold rst_n=0, then release with mem_ready=1.
  - Response: all outputs 0 during reset; first cycle after release is FETCH (mem_read=1, ir_write=1, pc_write=1).
- add (opcode 000000, func 100000), mem_ready=1.
  - Response: 4 cycles; EXEC_R shows alu_operation=010; WB shows reg_write=1, reg_dst=01, wb_sel=00; instr_done pulses once.
- lw with mem_ready low 2 cycles in FETCH and 3 cycles in MEM_RD.
  - Response: 10 cycles total; ir_write and mdr_write assert only in the ready cycle; WB shows wb_sel=01, reg_dst=00.
- beq with zero=1, then bne with zero=1.
  - Response: beq has pc_write=1 in BRANCH with pc_source=01; bne has pc_write=0; each instruction takes 3 cycles.
- jal (000011).
  - Response: third cycle asserts pc_write=1, pc_source=10, reg_write=1, reg_dst=10, wb_sel=10.
- Opcode 111111, then R-type func 000111.
  - Response: illegal pulses in the third cycle of each; no reg_write or mem_write occurs; the FSM returns to FETCH.
- Reset pulse in MEM_WR.
  - Response: mem_write drops to 0 immediately; the FSM restarts in FETCH.
